mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Initiator-side load/store unit that drives the single-port word memory's request interface on behalf of a core.
- Converts byte-addressed byte/half/word loads and stores into word-addressed, byte-masked memory transactions.
- Splits accesses that cross a word boundary into two beats, reassembles read data and sign/zero-extends it.
- Sits between core execute stage and mem; one outstanding request at a time.

Parameters:
- SPLIT_EN, 1: 1 = word-crossing accesses split into two beats; 0 = crossing access rejected with o_rsp_error, no memory traffic.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  unit idle, can accept request
- i_req_write  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- i_req_signed  in  1  load sign-extend (ignored for stores)
- i_req_wdata  in  32  store data, right-aligned
- o_rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- o_rsp_rdata  out  32  extended load data; 0 for stores
- o_rsp_error  out  1  valid with o_rsp_valid; crossing access with SPLIT_EN=0
- o_mem_en  out  1  memory request enable
- o_mem_write_en  out  1  memory write
- o_mem_addr  out  32  word address (byte address >> 2)
- o_mem_data  out  32  lane-aligned write data
- o_mem_mask  out  4  byte-lane enables; bit i = bits [8i+7:8i]
- i_mem_ready  in  1  memory can accept request
- i_mem_valid  in  1  read data valid
- i_mem_data  in  32  read data; unmasked lanes are zero

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except o_req_ready=1; captured request and read buffer cleared.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch addr/size/signed/write/wdata and go to ISSUE0. With SPLIT_EN=0 and a crossing access, go to RESP with the error flag set instead.
- Lane math: n = 1/2/4 bytes; off = addr[1:0]; crossing when off+n>4.
- Beat0: addr = A>>2; mask = (((1<<n)-1)<<off)[3:0]; data = wdata<<8*off.
- Beat1: addr = (A>>2)+1, wrapping 0x3FFFFFFF→0; mask = ((1<<n)-1)>>(4-off); data = wdata>>8*(4-off).
- ISSUEx: o_mem_en=1, other mem outputs driven from the latched beat values. Hold until i_mem_ready=1 at an edge.
  - Read: go to WAITx.
  - Write: go to ISSUE1 if crossing and in beat0, else RESP.
- WAITx: o_mem_en=0. On i_mem_valid, capture i_mem_data into a beat buffer, then go to ISSUE1 (crossing, beat0) or RESP.
- i_mem_valid outside WAITx is ignored, including stale data after reset.
- Assembly: raw = (b0>>8*off) | (b1<<8*(4-off)), with b1=0 if not crossing. Truncate to n bytes; sign-extend if i_req_signed, else zero-extend.
- RESP: o_rsp_valid=1 for exactly one cycle. rdata valid for loads, 0 for stores. Then IDLE.
- A new request is accepted no earlier than the cycle after RESP.
- Latency from acceptance edge E0, with i_mem_ready=1 and a 1-cycle memory:
  - Aligned load: o_rsp_valid in cycle 3.
  - Crossing load: cycle 5.
  - Aligned store: cycle 2.
  - Crossing store: cycle 3.
  - SPLIT_EN=0 error: cycle 1.
- Each cycle of i_mem_ready low adds one cycle of latency.

Test Plan:
- Mem word 0x10 = 0x88776655; load byte unsigned at 0x42 → one beat, addr 0x10, mask 0100; o_rsp_rdata=0x00000077, o_rsp_valid 3 cycles after accept.
- Load byte signed at 0x43 → mask 1000, o_rsp_rdata=0xFFFFFF88. Load half signed at 0x42 → mask 1100, rdata=0xFFFF8877.
- Word 0x11 = 0xDDCCBBAA; load word at 0x43 → beats (0x10, mask 1000), (0x11, mask 0111); rdata=0xCCBBAA88, o_rsp_valid at cycle 5.
- Store half 0x0000BEEF at 0x47 → beats (0x11, mask 1000, data 0xEF000000) then (0x12, mask 0001, data 0x000000BE); o_rsp_valid at cycle 3; readback word 0x11 = 0xEFCCBBAA.
- Hold i_mem_ready=0 for 4 cycles during ISSUE0 of an aligned load → o_mem_en and all mem outputs stable; o_rsp_valid at cycle 7.
- Assert i_rst in WAIT0, pulse i_mem_valid next cycle → outputs 0 immediately, o_req_ready=1, no o_rsp_valid. SPLIT_EN=0 with load word at 0x01 → no o_mem_en, o_rsp_valid and o_rsp_error at cycle 1.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte-addressed core loads/stores into word-addressed,
// byte-masked memory beats, splitting word-crossing accesses into two beats.
module mem_lsu #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    output logic        o_mem_en,
    output logic        o_mem_write_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        req_write_r;
    logic [31:0] req_addr_r;
    logic [1:0]  req_size_r;
    logic        req_signed_r;
    logic [31:0] req_wdata_r;
    logic [31:0] buf0_r;
    logic [31:0] buf1_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_error_r;
    logic        mem_en_r;
    logic        mem_write_en_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_r;
    logic [3:0]  mem_mask_r;

    logic        sel_write_s;
    logic [31:0] sel_addr_s;
    logic [1:0]  sel_size_s;
    logic        sel_signed_s;
    logic [31:0] sel_wdata_s;

    logic [1:0]  off_s;
    logic [7:0]  lane_mask_s;
    logic [63:0] lane_data_s;
    logic        crossing_s;
    logic [31:0] word_addr0_s;
    logic [31:0] word_addr1_s;

    logic [31:0] buf0_next_s;
    logic [31:0] buf1_next_s;
    logic        rsp_error_next_s;

    logic        issue_next_s;
    logic        beat1_next_s;
    logic [31:0] raw_s;
    logic [31:0] load_data_s;
    logic        mem_en_next_s;
    logic        mem_write_en_next_s;
    logic [31:0] mem_addr_next_s;
    logic [31:0] mem_data_next_s;
    logic [3:0]  mem_mask_next_s;
    logic [31:0] rsp_rdata_next_s;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] ext;
        case (size)
            2'd0:    ext = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    ext = {{16{sgn & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Request fields in effect: live inputs while idle so outputs can be registered at acceptance
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_write_s  = i_req_write;
            sel_addr_s   = i_req_addr;
            sel_size_s   = i_req_size;
            sel_signed_s = i_req_signed;
            sel_wdata_s  = i_req_wdata;
        end else begin
            sel_write_s  = req_write_r;
            sel_addr_s   = req_addr_r;
            sel_size_s   = req_size_r;
            sel_signed_s = req_signed_r;
            sel_wdata_s  = req_wdata_r;
        end
    end

    // Lane geometry: low nibble of the wide mask/data is beat 0, high nibble is beat 1
    always_comb begin
        off_s        = sel_addr_s[1:0];
        lane_mask_s  = {4'b0000, size_mask(sel_size_s)} << off_s;
        crossing_s   = |lane_mask_s[7:4];
        lane_data_s  = {32'h0000_0000, sel_wdata_s} << {off_s, 3'b000};
        word_addr0_s = {2'b00, sel_addr_s[31:2]};
        word_addr1_s = {2'b00, sel_addr_s[31:2] + 30'd1};
    end

    // Next-state and beat-buffer capture
    always_comb begin
        state_next_s     = state_r;
        buf0_next_s      = buf0_r;
        buf1_next_s      = buf1_r;
        rsp_error_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    buf0_next_s = 32'h0000_0000;
                    buf1_next_s = 32'h0000_0000;
                    if (!SPLIT_EN && crossing_s) begin
                        state_next_s     = ST_RESP;
                        rsp_error_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_ISSUE0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE0: begin
                if (!i_mem_ready) begin
                    state_next_s = ST_ISSUE0;
                end else if (!req_write_r) begin
                    state_next_s = ST_WAIT0;
                end else if (crossing_s) begin
                    state_next_s = ST_ISSUE1;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_WAIT0: begin
                if (i_mem_valid) begin
                    buf0_next_s  = i_mem_data;
                    state_next_s = crossing_s ? ST_ISSUE1 : ST_RESP;
                end else begin
                    state_next_s = ST_WAIT0;
                end
            end
            ST_ISSUE1: begin
                if (!i_mem_ready) begin
                    state_next_s = ST_ISSUE1;
                end else if (req_write_r) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (i_mem_valid) begin
                    buf1_next_s  = i_mem_data;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        issue_next_s = (state_next_s == ST_ISSUE0) || (state_next_s == ST_ISSUE1);
        beat1_next_s = (state_next_s == ST_ISSUE1);
        raw_s        = 32'({buf1_next_s, buf0_next_s} >> {off_s, 3'b000});
        load_data_s  = extend_load(raw_s, sel_size_s, sel_signed_s);
        if (issue_next_s) begin
            mem_en_next_s       = 1'b1;
            mem_write_en_next_s = sel_write_s;
            mem_addr_next_s     = beat1_next_s ? word_addr1_s : word_addr0_s;
            mem_data_next_s     = beat1_next_s ? lane_data_s[63:32] : lane_data_s[31:0];
            mem_mask_next_s     = beat1_next_s ? lane_mask_s[7:4] : lane_mask_s[3:0];
        end else begin
            mem_en_next_s       = 1'b0;
            mem_write_en_next_s = 1'b0;
            mem_addr_next_s     = 32'h0000_0000;
            mem_data_next_s     = 32'h0000_0000;
            mem_mask_next_s     = 4'b0000;
        end
        if ((state_next_s == ST_RESP) && !sel_write_s && !rsp_error_next_s) begin
            rsp_rdata_next_s = load_data_s;
        end else begin
            rsp_rdata_next_s = 32'h0000_0000;
        end
    end

    // State, latched request and read beat buffers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            req_write_r  <= 1'b0;
            req_addr_r   <= 32'h0000_0000;
            req_size_r   <= 2'd0;
            req_signed_r <= 1'b0;
            req_wdata_r  <= 32'h0000_0000;
            buf0_r       <= 32'h0000_0000;
            buf1_r       <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            buf0_r  <= buf0_next_s;
            buf1_r  <= buf1_next_s;
            if ((state_r == ST_IDLE) && i_req_valid) begin
                req_write_r  <= i_req_write;
                req_addr_r   <= i_req_addr;
                req_size_r   <= i_req_size;
                req_signed_r <= i_req_signed;
                req_wdata_r  <= i_req_wdata;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_error_r    <= 1'b0;
            mem_en_r       <= 1'b0;
            mem_write_en_r <= 1'b0;
            mem_addr_r     <= 32'h0000_0000;
            mem_data_r     <= 32'h0000_0000;
            mem_mask_r     <= 4'b0000;
        end else begin
            req_ready_r    <= (state_next_s == ST_IDLE);
            rsp_valid_r    <= (state_next_s == ST_RESP);
            rsp_rdata_r    <= rsp_rdata_next_s;
            rsp_error_r    <= rsp_error_next_s;
            mem_en_r       <= mem_en_next_s;
            mem_write_en_r <= mem_write_en_next_s;
            mem_addr_r     <= mem_addr_next_s;
            mem_data_r     <= mem_data_next_s;
            mem_mask_r     <= mem_mask_next_s;
        end
    end

    assign o_req_ready    = req_ready_r;
    assign o_rsp_valid    = rsp_valid_r;
    assign o_rsp_rdata    = rsp_rdata_r;
    assign o_rsp_error    = rsp_error_r;
    assign o_mem_en       = mem_en_r;
    assign o_mem_write_en = mem_write_en_r;
    assign o_mem_addr     = mem_addr_r;
    assign o_mem_data     = mem_data_r;
    assign o_mem_mask     = mem_mask_r;

endmodule
